ysyx_22050019_rd_arbiter: RTL and testbench

- Two-master to one-slave AXI-style read-channel arbiter.
- Shares the single memory read port between the icache refill port (master 0) and the dcache/uncached load port (master 1).
- Round-robin grant; each grant is held for one complete transaction, from address handshake to final data beat.
- Counts beats itself and flags slave last-beat mismatches.

---
 rtl/ysyx_22050019_rd_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ysyx_22050019_rd_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_rd_arbiter.sv
// Two-master round-robin arbiter for the shared memory read port (icache = m0, dcache = m1).
// A grant is held from the address handshake through the final beat; beats are counted locally.
module ysyx_22050019_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0: icache refill
    input  logic                  m0_ar_valid_i,
    output logic                  m0_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] m0_ar_addr_i,
    input  logic [LEN_WIDTH-1:0]  m0_ar_len_i,
    output logic                  m0_r_valid_o,
    input  logic                  m0_r_ready_i,
    output logic [1:0]            m0_r_resp_o,
    output logic [DATA_WIDTH-1:0] m0_r_data_o,
    output logic                  m0_r_last_o,
    // master 1: dcache / uncached load
    input  logic                  m1_ar_valid_i,
    output logic                  m1_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] m1_ar_addr_i,
    input  logic [LEN_WIDTH-1:0]  m1_ar_len_i,
    output logic                  m1_r_valid_o,
    input  logic                  m1_r_ready_i,
    output logic [1:0]            m1_r_resp_o,
    output logic [DATA_WIDTH-1:0] m1_r_data_o,
    output logic                  m1_r_last_o,
    // slave: memory read port
    output logic                  s_ar_valid_o,
    input  logic                  s_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] s_ar_addr_o,
    output logic [LEN_WIDTH-1:0]  s_ar_len_o,
    input  logic                  s_r_valid_i,
    output logic                  s_r_ready_o,
    input  logic [1:0]            s_r_resp_i,
    input  logic [DATA_WIDTH-1:0] s_r_data_i,
    input  logic                  s_r_last_i,
    // status
    output logic                  busy_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   err_q, err_d;

    logic                   in_ar;
    logic                   in_r;
    logic                   r_sel0;
    logic                   r_sel1;
    logic                   sel_ar_valid;
    logic [ADDR_WIDTH-1:0]  sel_ar_addr;
    logic [LEN_WIDTH-1:0]   sel_ar_len;
    logic                   sel_r_ready;
    logic                   last_hit;
    logic                   ar_hs;
    logic                   beat_hs;

    // Outputs are masked while rst is high so an aborted burst forwards nothing more.
    assign in_ar  = (state_q == ST_AR) && !rst;
    assign in_r   = (state_q == ST_R)  && !rst;
    assign r_sel0 = in_r && !grant_q;
    assign r_sel1 = in_r &&  grant_q;

    assign sel_ar_valid = grant_q ? m1_ar_valid_i : m0_ar_valid_i;
    assign sel_ar_addr  = grant_q ? m1_ar_addr_i  : m0_ar_addr_i;
    assign sel_ar_len   = grant_q ? m1_ar_len_i   : m0_ar_len_i;
    assign sel_r_ready  = grant_q ? m1_r_ready_i  : m0_r_ready_i;

    // Termination follows the local count; the slave's last flag is only cross-checked.
    assign last_hit = (beat_cnt_q == len_q);
    assign ar_hs    = s_ar_valid_o && s_ar_ready_i;
    assign beat_hs  = s_r_valid_i && s_r_ready_o;

    assign s_ar_valid_o  = in_ar && sel_ar_valid;
    assign s_ar_addr_o   = in_ar ? sel_ar_addr : '0;
    assign s_ar_len_o    = in_ar ? sel_ar_len  : '0;
    assign m0_ar_ready_o = in_ar && !grant_q && s_ar_ready_i;
    assign m1_ar_ready_o = in_ar &&  grant_q && s_ar_ready_i;

    assign s_r_ready_o   = in_r && sel_r_ready;

    assign m0_r_valid_o  = r_sel0 && s_r_valid_i;
    assign m0_r_resp_o   = r_sel0 ? s_r_resp_i : 2'b00;
    assign m0_r_data_o   = r_sel0 ? s_r_data_i : '0;
    assign m0_r_last_o   = r_sel0 && last_hit;

    assign m1_r_valid_o  = r_sel1 && s_r_valid_i;
    assign m1_r_resp_o   = r_sel1 ? s_r_resp_i : 2'b00;
    assign m1_r_data_o   = r_sel1 ? s_r_data_i : '0;
    assign m1_r_last_o   = r_sel1 && last_hit;

    assign busy_o = (state_q != ST_IDLE) && !rst;
    assign err_o  = err_q && !rst;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (m0_ar_valid_i || m1_ar_valid_i) begin
                    state_d = ST_AR;
                    if (m0_ar_valid_i && m1_ar_valid_i) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = m1_ar_valid_i;
                    end
                end
            end

            ST_AR: begin
                if (!sel_ar_valid) begin
                    state_d = ST_IDLE;
                end else if (ar_hs) begin
                    state_d    = ST_R;
                    len_d      = sel_ar_len;
                    beat_cnt_d = '0;
                end
            end

            ST_R: begin
                if (beat_hs) begin
                    if (s_r_last_i != last_hit) begin
                        err_d = 1'b1;
                    end
                    if (last_hit) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_rd_arbiter.sv
// Scoreboard bench for the two-master read arbiter: expected beats are queued as the slave
// side is driven and popped when a master sees a beat handshake.
module tb_ysyx_22050019_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_ar_valid_i, m1_ar_valid_i;
    logic [31:0] m0_ar_addr_i, m1_ar_addr_i;
    logic [7:0]  m0_ar_len_i, m1_ar_len_i;
    logic        m0_r_ready_i, m1_r_ready_i;
    logic        s_ar_ready_i, s_r_valid_i, s_r_last_i;
    logic [1:0]  s_r_resp_i;
    logic [63:0] s_r_data_i;

    logic        m0_ar_ready_o, m0_r_valid_o, m0_r_last_o;
    logic [1:0]  m0_r_resp_o;
    logic [63:0] m0_r_data_o;
    logic        m1_ar_ready_o, m1_r_valid_o, m1_r_last_o;
    logic [1:0]  m1_r_resp_o;
    logic [63:0] m1_r_data_o;
    logic        s_ar_valid_o, s_r_ready_o, busy_o, err_o;
    logic [31:0] s_ar_addr_o;
    logic [7:0]  s_ar_len_o;

    logic [68:0]  m0_out, m1_out;
    logic [181:0] all_out;
    assign m0_out  = {m0_ar_ready_o, m0_r_valid_o, m0_r_resp_o, m0_r_data_o, m0_r_last_o};
    assign m1_out  = {m1_ar_ready_o, m1_r_valid_o, m1_r_resp_o, m1_r_data_o, m1_r_last_o};
    assign all_out = {m0_out, m1_out, s_ar_valid_o, s_ar_addr_o, s_ar_len_o,
                      s_r_ready_o, busy_o, err_o};

    typedef struct packed {
        logic        mst;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_mis = 0;

    always #5 clk = ~clk;

    ysyx_22050019_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_ready_o(m0_ar_ready_o),
        .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_len_i(m0_ar_len_i),
        .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready_i),
        .m0_r_resp_o(m0_r_resp_o), .m0_r_data_o(m0_r_data_o), .m0_r_last_o(m0_r_last_o),
        .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_ready_o(m1_ar_ready_o),
        .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_len_i(m1_ar_len_i),
        .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready_i),
        .m1_r_resp_o(m1_r_resp_o), .m1_r_data_o(m1_r_data_o), .m1_r_last_o(m1_r_last_o),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i),
        .s_ar_addr_o(s_ar_addr_o), .s_ar_len_o(s_ar_len_o),
        .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o),
        .s_r_resp_i(s_r_resp_i), .s_r_data_i(s_r_data_i), .s_r_last_i(s_r_last_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_ar_valid_i = 1'b0; m0_ar_addr_i = '0; m0_ar_len_i = '0; m0_r_ready_i = 1'b0;
        m1_ar_valid_i = 1'b0; m1_ar_addr_i = '0; m1_ar_len_i = '0; m1_r_ready_i = 1'b0;
        s_ar_ready_i = 1'b0; s_r_valid_i = 1'b0; s_r_last_i = 1'b0;
        s_r_resp_i = 2'b00; s_r_data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    function automatic beat_t obs_beat();
        beat_t b;
        b.mst  = m1_r_valid_o;
        b.data = m1_r_valid_o ? m1_r_data_o : m0_r_data_o;
        b.resp = m1_r_valid_o ? m1_r_resp_o : m0_r_resp_o;
        b.last = m1_r_valid_o ? m1_r_last_o : m0_r_last_o;
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m0_ar_valid_i = 1'b1; m0_r_ready_i = 1'b1; s_r_valid_i = 1'b1; s_ar_ready_i = 1'b1;
        s_r_data_i = 64'hDEAD_BEEF; s_r_last_i = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_vec++; if (all_out !== '0) begin n_mis++; $display("FAIL reset_held_outs: got %h, expected 0", all_out); end
        rst = 1'b0;
        clear_inputs();
        tick();
        @(negedge clk);
        n_vec++; if (all_out !== '0) begin n_mis++; $display("FAIL reset_idle_outs: got %h, expected 0", all_out); end
    endtask

    task automatic test_single_m0();
        beat_t b, e;
        exp_q.delete();
        tick();
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0010; m0_ar_len_i = 8'd1;
        s_ar_ready_i = 1'b1; m0_r_ready_i = 1'b1;
        @(negedge clk);
        n_vec++; if (all_out !== '0) begin n_mis++; $display("FAIL single_idle_bubble: got %h, expected 0", all_out); end
        tick();
        @(negedge clk);
        n_vec++;
        if ({s_ar_valid_o, s_ar_addr_o, s_ar_len_o, m0_ar_ready_o, m1_ar_ready_o, busy_o} !== {1'b1, 32'h8000_0010, 8'd1, 1'b1, 1'b0, 1'b1}) begin
            n_mis++; $display("FAIL single_ar: got v=%b a=%h l=%h rdy=%b%b busy=%b, expected v=1 a=80000010 l=01 rdy=01 busy=1",
                              s_ar_valid_o, s_ar_addr_o, s_ar_len_o, m1_ar_ready_o, m0_ar_ready_o, busy_o);
        end
        tick();
        m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_r_valid_i = 1'b1; s_r_data_i = 64'hA + 64'(i); s_r_last_i = (i == 1); s_r_resp_i = 2'b00;
            exp_q.push_back(beat_t'{1'b0, 64'hA + 64'(i), 2'b00, (i == 1)});
            @(negedge clk);
            b = obs_beat();
            n_vec++;
            if (!(m0_r_valid_o && s_r_ready_o) || exp_q.size() == 0) begin
                n_mis++; $display("FAIL single_beat%0d: got valid=%b ready=%b, expected a beat handshake", i, m0_r_valid_o, s_r_ready_o);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin n_mis++; $display("FAIL single_beat%0d: got %h, expected %h", i, b, e); end
            end
            n_vec++; if (m1_out !== '0) begin n_mis++; $display("FAIL single_m1_quiet%0d: got %h, expected 0", i, m1_out); end
            tick();
        end
        s_r_valid_i = 1'b0; s_r_last_i = 1'b0;
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL single_busy_fall: got %b, expected 0", busy_o); end
    endtask

    task automatic test_round_robin();
        beat_t b, e;
        logic  mst;
        do_reset();
        exp_q.delete();
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h0000_1000; m0_ar_len_i = 8'd0;
        m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h0000_2000; m1_ar_len_i = 8'd0;
        s_ar_ready_i = 1'b1; m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            mst = t[0];
            @(negedge clk);
            n_vec++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rr_gap%0d: busy got %b, expected 0", t, busy_o); end
            tick();
            @(negedge clk);
            n_vec++;
            if ({s_ar_valid_o, s_ar_addr_o, m1_ar_ready_o, m0_ar_ready_o} !== {1'b1, (mst ? 32'h0000_2000 : 32'h0000_1000), mst, ~mst}) begin
                n_mis++; $display("FAIL rr_grant%0d: got v=%b a=%h rdy=%b%b, expected master %0d", t, s_ar_valid_o, s_ar_addr_o, m1_ar_ready_o, m0_ar_ready_o, mst);
            end
            tick();
            s_r_valid_i = 1'b1; s_r_data_i = 64'h100 + 64'(t); s_r_last_i = 1'b1; s_r_resp_i = 2'b01;
            exp_q.push_back(beat_t'{mst, 64'h100 + 64'(t), 2'b01, 1'b1});
            @(negedge clk);
            b = obs_beat();
            n_vec++;
            if (!(m0_r_valid_o || m1_r_valid_o) || exp_q.size() == 0) begin
                n_mis++; $display("FAIL rr_beat%0d: got no beat (valid=%b%b), expected one", t, m1_r_valid_o, m0_r_valid_o);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin n_mis++; $display("FAIL rr_beat%0d: got %h, expected %h", t, b, e); end
            end
            tick();
            s_r_valid_i = 1'b0; s_r_last_i = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_ar_stall();
        beat_t b, e;
        exp_q.delete();
        tick();
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0040; m0_ar_len_i = 8'd0;
        s_ar_ready_i = 1'b0; m0_r_ready_i = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tick();
            s_ar_ready_i = (k == 3);
            @(negedge clk);
            n_vec++;
            if ({s_ar_valid_o, s_ar_addr_o, m0_ar_ready_o} !== {1'b1, 32'h8000_0040, (k == 3)}) begin
                n_mis++; $display("FAIL stall_ar%0d: got v=%b a=%h rdy=%b, expected v=1 a=80000040 rdy=%b", k, s_ar_valid_o, s_ar_addr_o, m0_ar_ready_o, (k == 3));
            end
        end
        tick();
        m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
        s_r_valid_i = 1'b1; s_r_data_i = 64'h00C0_FFEE; s_r_last_i = 1'b1; s_r_resp_i = 2'b10;
        exp_q.push_back(beat_t'{1'b0, 64'h00C0_FFEE, 2'b10, 1'b1});
        @(negedge clk);
        b = obs_beat();
        n_vec++;
        if (!m0_r_valid_o || s_ar_valid_o || exp_q.size() == 0) begin
            n_mis++; $display("FAIL stall_beat: got r_valid=%b s_ar_valid=%b, expected 1 and 0", m0_r_valid_o, s_ar_valid_o);
        end else begin
            e = exp_q.pop_front();
            if (b !== e) begin n_mis++; $display("FAIL stall_beat: got %h, expected %h", b, e); end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        beat_t b, e;
        int    beat = 0;
        exp_q.delete();
        tick();
        m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h9000_0000; m1_ar_len_i = 8'd3; s_ar_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(beat_t'{1'b1, 64'hD0 + 64'(i), 2'(i), (i == 3)});
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        m1_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0; s_r_valid_i = 1'b1;
        for (int cyc = 0; cyc < 30 && beat < 4; cyc++) begin
            m1_r_ready_i = (cyc % 2 == 0);
            s_r_data_i = 64'hD0 + 64'(beat); s_r_resp_i = 2'(beat); s_r_last_i = (beat == 3);
            @(negedge clk);
            n_vec++; if (s_r_ready_o !== m1_r_ready_i) begin n_mis++; $display("FAIL bp_ready_c%0d: got %b, expected %b", cyc, s_r_ready_o, m1_r_ready_i); end
            if (m1_r_valid_o && m1_r_ready_i) begin
                b = obs_beat();
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_mis++; $display("FAIL bp_beat%0d: got %h, expected no further beat", beat, b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin n_mis++; $display("FAIL bp_beat%0d: got %h, expected %h", beat, b, e); end
                end
                n_vec++; if (m0_out !== '0) begin n_mis++; $display("FAIL bp_m0_quiet%0d: got %h, expected 0", beat, m0_out); end
                beat++;
            end
            tick();
        end
        n_vec++; if (beat != 4) begin n_mis++; $display("FAIL bp_count: got %0d beats, expected 4 within budget", beat); end
        clear_inputs();
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL bp_done: busy got %b, expected 0", busy_o); end
    endtask

    task automatic test_err();
        beat_t b, e;
        exp_q.delete();
        tick();
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0100; m0_ar_len_i = 8'd1;
        s_ar_ready_i = 1'b1; m0_r_ready_i = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_r_valid_i = 1'b1; s_r_data_i = 64'hE0 + 64'(i); s_r_last_i = 1'b1; s_r_resp_i = 2'b00;
            exp_q.push_back(beat_t'{1'b0, 64'hE0 + 64'(i), 2'b00, (i == 1)});
            @(negedge clk);
            n_vec++; if (err_o !== (i == 1)) begin n_mis++; $display("FAIL err_flag_b%0d: got %b, expected %b", i, err_o, (i == 1)); end
            b = obs_beat();
            n_vec++;
            if (!m0_r_valid_o || exp_q.size() == 0) begin
                n_mis++; $display("FAIL err_beat%0d: got no beat, expected one", i);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin n_mis++; $display("FAIL err_beat%0d: got %h, expected %h", i, b, e); end
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        n_vec++; if ({busy_o, err_o} !== 2'b01) begin n_mis++; $display("FAIL err_done: got busy/err %b%b, expected 01", busy_o, err_o); end
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL err_sticky: got %b, expected 1", err_o); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL err_clear: got %b, expected 0", err_o); end
    endtask

    task automatic test_reset_mid();
        beat_t b, e;
        exp_q.delete();
        tick();
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h8000_0200; m0_ar_len_i = 8'd3;
        s_ar_ready_i = 1'b1; m0_r_ready_i = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        m0_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_r_valid_i = 1'b1; s_r_data_i = 64'hF0 + 64'(i); s_r_last_i = 1'b0;
            exp_q.push_back(beat_t'{1'b0, 64'hF0 + 64'(i), 2'b00, 1'b0});
            @(negedge clk);
            b = obs_beat();
            n_vec++;
            if (!m0_r_valid_o || exp_q.size() == 0) begin
                n_mis++; $display("FAIL mid_beat%0d: got no beat, expected one", i);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin n_mis++; $display("FAIL mid_beat%0d: got %h, expected %h", i, b, e); end
            end
            tick();
        end
        rst = 1'b1; s_r_data_i = 64'hF2;
        @(negedge clk);
        n_vec++; if (all_out !== '0) begin n_mis++; $display("FAIL mid_rst_cycle: got %h, expected 0", all_out); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (all_out !== '0) begin n_mis++; $display("FAIL mid_after_rst: got %h, expected 0", all_out); end
        tick();
        clear_inputs();
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 32'h0000_AAA0;
        m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h0000_BBB0;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_vec++; if ({s_ar_valid_o, s_ar_addr_o} !== {1'b1, 32'h0000_AAA0}) begin n_mis++; $display("FAIL mid_tie_grant: got v=%b a=%h, expected v=1 a=0000aaa0", s_ar_valid_o, s_ar_addr_o); end
        tick();
        m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0;
        @(negedge clk);
        n_vec++; if ({s_ar_valid_o, busy_o} !== 2'b01) begin n_mis++; $display("FAIL mid_withdraw: got v/busy %b%b, expected 01", s_ar_valid_o, busy_o); end
        tick();
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL mid_withdraw_idle: busy got %b, expected 0", busy_o); end
        tick();
        m1_ar_valid_i = 1'b1; m1_ar_addr_i = 32'h8000_0300; m1_ar_len_i = 8'd1;
        s_ar_ready_i = 1'b1; m1_r_ready_i = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_vec++; if ({s_ar_addr_o, s_ar_len_o, m1_ar_ready_o} !== {32'h8000_0300, 8'd1, 1'b1}) begin n_mis++; $display("FAIL fresh_ar: got a=%h l=%h rdy=%b, expected 80000300 01 1", s_ar_addr_o, s_ar_len_o, m1_ar_ready_o); end
        tick();
        m1_ar_valid_i = 1'b0; s_ar_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_r_valid_i = 1'b1; s_r_data_i = 64'h11 + 64'(i); s_r_last_i = (i == 1); s_r_resp_i = 2'b11;
            exp_q.push_back(beat_t'{1'b1, 64'h11 + 64'(i), 2'b11, (i == 1)});
            @(negedge clk);
            b = obs_beat();
            n_vec++;
            if (!m1_r_valid_o || exp_q.size() == 0) begin
                n_mis++; $display("FAIL fresh_beat%0d: got no beat, expected one", i);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin n_mis++; $display("FAIL fresh_beat%0d: got %h, expected %h", i, b, e); end
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        n_vec++; if ({busy_o, err_o} !== 2'b00) begin n_mis++; $display("FAIL fresh_done: got busy/err %b%b, expected 00", busy_o, err_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_m0();
        test_round_robin();
        test_ar_stall();
        test_backpressure();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
